// File: rtl/elevator_request_buffer_if.sv
// Request-buffer bus: car position/status and raw buttons in, latched calls and summaries out.
interface elevator_request_buffer_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3,
    parameter int unsigned STATUS_W   = 4,
    parameter int unsigned CNT_W      = 4
);
    logic [FLOOR_W-1:0]    floor;
    logic [STATUS_W-1:0]   status;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] upcall_input;
    logic [NUM_FLOORS-1:0] downcall_input;
    logic [NUM_FLOORS-1:0] floor_btn_input;
    logic [NUM_FLOORS-1:0] upcall;
    logic [NUM_FLOORS-1:0] downcall;
    logic [NUM_FLOORS-1:0] floor_btn;
    logic                  req_above;
    logic                  req_below;
    logic                  req_here;
    logic [CNT_W-1:0]      pending_cnt;
    logic                  served;

    // Driver side: input sync / scheduler environment.
    modport master (
        output floor, status, dir_up, upcall_input, downcall_input, floor_btn_input,
        input  upcall, downcall, floor_btn, req_above, req_below, req_here, pending_cnt, served
    );

    // Request buffer side.
    modport slave (
        input  floor, status, dir_up, upcall_input, downcall_input, floor_btn_input,
        output upcall, downcall, floor_btn, req_above, req_below, req_here, pending_cnt, served
    );
endinterface

// File: rtl/elevator_request_buffer.sv
// Hall-call / car-call request latch. Captures button rising edges, holds them until the
// car serves the floor with the door open, and summarises pending work for the scheduler.
module elevator_request_buffer #(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned STATUS_W     = 4,
    parameter int unsigned ST_DOOR_OPEN = 7,
    parameter int unsigned DIR_AWARE    = 1,
    parameter int unsigned CANCEL_EN    = 1,
    parameter int unsigned CNT_W        = 4
) (
    input logic                        clk,
    input logic                        rst,
    elevator_request_buffer_if.slave   bus
);

    logic [NUM_FLOORS-1:0] r_upcall, r_downcall, r_floor_btn;
    logic [NUM_FLOORS-1:0] r_up_prev, r_dn_prev, r_btn_prev;
    logic                  r_served;

    logic [NUM_FLOORS-1:0] w_up_press, w_dn_press, w_btn_press;
    logic [NUM_FLOORS-1:0] w_here_mask, w_above_mask, w_below_mask;
    logic [NUM_FLOORS-1:0] w_any;
    logic [NUM_FLOORS-1:0] w_up_clr, w_dn_clr, w_btn_clr, w_btn_cancel;
    logic [NUM_FLOORS-1:0] w_upcall_d, w_downcall_d, w_floor_btn_d;
    logic                  w_floor_ok, w_door_open, w_served_d;
    logic                  w_req_above, w_req_below, w_req_here;
    logic [CNT_W-1:0]      w_cnt;

    // Position decode: one-hot here, thermometer above/below; all zero for an out-of-range floor.
    always_comb begin
        w_floor_ok   = (32'(bus.floor) < NUM_FLOORS);
        w_door_open  = w_floor_ok && (bus.status == STATUS_W'(ST_DOOR_OPEN));
        w_here_mask  = '0;
        w_above_mask = '0;
        w_below_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_here_mask[i]  = w_floor_ok && (i == 32'(bus.floor));
            w_above_mask[i] = w_floor_ok && (i > 32'(bus.floor));
            w_below_mask[i] = w_floor_ok && (i < 32'(bus.floor));
        end
    end

    // Summaries from the registered request state.
    always_comb begin
        w_any       = r_upcall | r_downcall | r_floor_btn;
        w_req_above = |(w_any & w_above_mask);
        w_req_below = |(w_any & w_below_mask);
        w_req_here  = |(w_any & w_here_mask);
        w_cnt       = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_cnt = w_cnt + CNT_W'(w_any[i]);
        end
    end

    // Edge detect, door-open clearing, cancel, and next-state request vectors.
    always_comb begin
        w_up_press  = bus.upcall_input & ~r_up_prev;
        w_dn_press  = bus.downcall_input & ~r_dn_prev;
        w_btn_press = bus.floor_btn_input & ~r_btn_prev;

        w_btn_clr = w_door_open ? w_here_mask : '0;
        w_up_clr  = '0;
        w_dn_clr  = '0;
        if (DIR_AWARE != 0) begin
            // Keep the opposite-direction hall call while work remains on that side.
            if (w_door_open && (bus.dir_up || !w_req_above)) w_up_clr = w_here_mask;
            if (w_door_open && (!bus.dir_up || !w_req_below)) w_dn_clr = w_here_mask;
        end else begin
            w_up_clr = w_btn_clr;
            w_dn_clr = w_btn_clr;
        end

        w_btn_cancel = (CANCEL_EN != 0) ? (w_btn_press & r_floor_btn) : '0;

        // Clear is applied last so a press at the floor being served never latches.
        w_upcall_d    = (r_upcall | w_up_press) & ~w_up_clr;
        w_downcall_d  = (r_downcall | w_dn_press) & ~w_dn_clr;
        w_floor_btn_d = ((r_floor_btn | w_btn_press) & ~w_btn_cancel) & ~w_btn_clr;

        // Only previously latched bits count as served; cancels and suppressed presses do not.
        w_served_d = |((r_upcall & w_up_clr) | (r_downcall & w_dn_clr) |
                       (r_floor_btn & w_btn_clr));
    end

    // State update with synchronous reset; edge history cleared so held buttons re-register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upcall    <= '0;
            r_downcall  <= '0;
            r_floor_btn <= '0;
            r_up_prev   <= '0;
            r_dn_prev   <= '0;
            r_btn_prev  <= '0;
            r_served    <= 1'b0;
        end else begin
            r_upcall    <= w_upcall_d;
            r_downcall  <= w_downcall_d;
            r_floor_btn <= w_floor_btn_d;
            r_up_prev   <= bus.upcall_input;
            r_dn_prev   <= bus.downcall_input;
            r_btn_prev  <= bus.floor_btn_input;
            r_served    <= w_served_d;
        end
    end

    assign bus.upcall      = r_upcall;
    assign bus.downcall    = r_downcall;
    assign bus.floor_btn   = r_floor_btn;
    assign bus.req_above   = w_req_above;
    assign bus.req_below   = w_req_below;
    assign bus.req_here    = w_req_here;
    assign bus.pending_cnt = w_cnt;
    assign bus.served      = r_served;

endmodule

// File: tb/tb_elevator_request_buffer.sv
// Directed vector bench for elevator_request_buffer (8 floors, 4-bit floor index).
module tb_elevator_request_buffer;

    localparam int unsigned NF = 8;
    localparam int unsigned FW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_request_buffer_if #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .STATUS_W(4), .CNT_W(4)
    ) bus ();

    elevator_request_buffer #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .STATUS_W(4), .ST_DOOR_OPEN(7),
        .DIR_AWARE(1), .CANCEL_EN(1), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] floor;
        logic [3:0] status;
        logic       dir_up;
        logic [7:0] up_in, dn_in, btn_in;
        logic [7:0] e_up, e_dn, e_btn;
        logic       e_above, e_below, e_here;
        logic [3:0] e_cnt;
        logic       e_served;
    } vec_t;

    vec_t vecs[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic add(input logic r, input logic [3:0] f, input logic [3:0] s, input logic d,
                       input logic [7:0] ui, input logic [7:0] di, input logic [7:0] bi,
                       input logic [7:0] eu, input logic [7:0] ed, input logic [7:0] eb,
                       input logic ea, input logic ebl, input logic eh,
                       input logic [3:0] ec, input logic es);
        vec_t v;
        v.rst = r; v.floor = f; v.status = s; v.dir_up = d;
        v.up_in = ui; v.dn_in = di; v.btn_in = bi;
        v.e_up = eu; v.e_dn = ed; v.e_btn = eb;
        v.e_above = ea; v.e_below = ebl; v.e_here = eh;
        v.e_cnt = ec; v.e_served = es;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] f, input logic [3:0] s,
                         input logic d, input logic [7:0] ui, input logic [7:0] di,
                         input logic [7:0] bi);
        @(negedge clk);
        rst = r;
        bus.floor = f; bus.status = s; bus.dir_up = d;
        bus.upcall_input = ui; bus.downcall_input = di; bus.floor_btn_input = bi;
        @(posedge clk);
        #1;
    endtask

    int served_cycles;

    initial begin
        bus.floor = '0; bus.status = '0; bus.dir_up = 1'b0;
        bus.upcall_input = '0; bus.downcall_input = '0; bus.floor_btn_input = '0;

        //   rst f  st d  up_in  dn_in  btn_in  e_up   e_dn   e_btn  ab bl hr cnt sv
        // Reset with everything pressed, then release: held buttons register once.
        add(1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 8, 0);
        add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // Car button 5, served at floor 5: served pulses one cycle.
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20, 1, 0, 0, 1, 0);
        add(0, 5, 7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        add(0, 5, 7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // Direction-aware: up/down at 3, car calls 1 and 6.
        add(0, 0, 0, 0, 8'h08, 8'h08, 8'h42, 8'h08, 8'h08, 8'h42, 1, 0, 0, 3, 0);
        add(0, 3, 7, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h42, 1, 1, 1, 3, 1);
        add(0, 6, 7, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h02, 0, 1, 0, 2, 1);
        add(0, 1, 7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 1, 0, 0, 1, 1);
        add(0, 3, 7, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        // Up call at 4 kept while heading down with work above, cleared once none left.
        add(0, 0, 0, 0, 8'h10, 8'h00, 8'h80, 8'h10, 8'h00, 8'h80, 1, 0, 0, 2, 0);
        add(0, 4, 7, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h80, 1, 0, 1, 2, 0);
        add(0, 7, 7, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 0, 1, 0, 1, 1);
        add(0, 4, 7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        // Cancel: second press on lit car button 2 clears it; a held button is one press.
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // Summaries at floor 4, then out-of-range floors clear nothing.
        add(0, 4, 0, 0, 8'h02, 8'h40, 8'h00, 8'h02, 8'h40, 8'h00, 1, 1, 0, 2, 0);
        add(0, 9, 7, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h40, 8'h00, 0, 0, 0, 2, 0);
        add(0, 15, 7, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h40, 8'h00, 0, 0, 0, 2, 0);
        add(0, 8, 7, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h40, 8'h00, 0, 0, 0, 2, 0);
        add(0, 1, 7, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 1, 0, 0, 1, 1);
        add(0, 6, 7, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        // Press at the open-door floor never latches; held afterwards stays clear.
        add(0, 2, 7, 0, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 2, 0, 0, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // Reset mid-sequence, buttons held through it re-register after release.
        add(0, 0, 0, 0, 8'h11, 8'h00, 8'h08, 8'h11, 8'h00, 8'h08, 1, 0, 1, 3, 0);
        add(1, 0, 0, 0, 8'h11, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h11, 8'h00, 8'h08, 8'h11, 8'h00, 8'h08, 1, 0, 1, 3, 0);
        add(0, 0, 0, 0, 8'h11, 8'h00, 8'h08, 8'h11, 8'h00, 8'h08, 1, 0, 1, 3, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].floor, vecs[i].status, vecs[i].dir_up,
                  vecs[i].up_in, vecs[i].dn_in, vecs[i].btn_in);
            check("upcall",      i, 32'(bus.upcall),      32'(vecs[i].e_up));
            check("downcall",    i, 32'(bus.downcall),    32'(vecs[i].e_dn));
            check("floor_btn",   i, 32'(bus.floor_btn),   32'(vecs[i].e_btn));
            check("req_above",   i, 32'(bus.req_above),   32'(vecs[i].e_above));
            check("req_below",   i, 32'(bus.req_below),   32'(vecs[i].e_below));
            check("req_here",    i, 32'(bus.req_here),    32'(vecs[i].e_here));
            check("pending_cnt", i, 32'(bus.pending_cnt), 32'(vecs[i].e_cnt));
            check("served",      i, 32'(bus.served),      32'(vecs[i].e_served));
        end

        // Door held open at floor 7 for several cycles: served is a single-cycle pulse.
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h80);
        check("seq_press7", 100, 32'(bus.floor_btn), 32'h88);
        served_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 7, 7, 0, 8'h00, 8'h00, 8'h00);
            if (bus.served === 1'b1) served_cycles++;
        end
        check("seq_served_width", 101, 32'(served_cycles), 32'd1);
        check("seq_btn_after",    102, 32'(bus.floor_btn), 32'h08);
        check("seq_up_after",     103, 32'(bus.upcall), 32'h11);
        check("seq_cnt_after",    104, 32'(bus.pending_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
